// File: rtl/exc_ctrl.sv
// exc_ctrl: M-stage exception/interrupt sequencer driving CP0 and the NPC redirect (optional BD handling: EXC_BD_EN)
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ExcReqM,
  input  logic [4:0]  ExcCodeM,
  input  logic [31:0] PCM,
  input  logic        BDM,
  input  logic        EretM,
  input  logic [5:0]  HWInt,
  input  logic [31:0] SRIn,
  input  logic [31:0] EPCIn,
  output logic        CP0Req,
  output logic [4:0]  CP0ExcCode,
  output logic [31:0] CP0VPC,
  output logic        CP0BD,
  output logic        CP0EXLClr,
  output logic [5:0]  IPOut,
  output logic        FlushAll,
  output logic        NPCSel,
  output logic [31:0] NPC,
  output logic        Busy,
  output logic [7:0]  DropCnt
);
  typedef enum logic [2:0] {IDLE, TAKE, FLUSH, REDIR, RET} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [4:0] code;
  logic [31:0] vpc;
  logic int_pend, exc_pend, idle;
  logic unused_bits;
  assign idle     = state == IDLE;
  assign int_pend = |(IPOut & SRIn[15:10]) & SRIn[0] & ~SRIn[1];
  assign exc_pend = ExcReqM & ~SRIn[1];
`ifdef EXC_BD_EN
  logic bd;
  assign unused_bits = ^{SRIn[31:16], SRIn[9:2]};
`else
  assign unused_bits = ^{SRIn[31:16], SRIn[9:2], BDM};
`endif
  // state register
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) state <= IDLE;
    else state <= state_nx;
  // next-state: arbitrate in IDLE, then walk the fixed flush window
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (int_pend || exc_pend) ? TAKE : EretM ? RET : IDLE;
      TAKE:    state_nx = FLUSH;
      FLUSH:   state_nx = cnt == 4'd0 ? REDIR : FLUSH;
      default: state_nx = IDLE;
    endcase
  end
  // interrupt sampling, flush counter, latched CP0 payload and drop counter
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      IPOut   <= '0;
      cnt     <= '0;
      code    <= '0;
      vpc     <= '0;
      DropCnt <= '0;
`ifdef EXC_BD_EN
      bd      <= 1'b0;
`endif
    end else begin
      IPOut <= HWInt;
      cnt   <= state == TAKE ? 4'(FLUSH_CYCLES - 1) : state == FLUSH ? cnt - 4'd1 : cnt;
      if (idle && (int_pend || exc_pend)) begin
        code <= int_pend ? 5'd0 : ExcCodeM;
`ifdef EXC_BD_EN
        vpc  <= BDM ? PCM - 32'd4 : PCM;
        bd   <= BDM;
`else
        vpc  <= PCM;
`endif
      end
      if (idle && ExcReqM && SRIn[1] && DropCnt != 8'hFF) DropCnt <= DropCnt + 8'd1;
    end
  // state-decoded outputs
  always_comb begin
    CP0Req     = state == TAKE;
    CP0EXLClr  = state == RET;
    FlushAll   = state == TAKE || state == FLUSH || state == RET;
    NPCSel     = state == REDIR || state == RET;
    NPC        = state == REDIR ? HANDLER_ADDR : state == RET ? EPCIn : 32'd0;
    Busy       = !idle;
    CP0ExcCode = code;
    CP0VPC     = vpc;
`ifdef EXC_BD_EN
    CP0BD      = bd;
`else
    CP0BD      = 1'b0;
`endif
  end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: scoreboard bench for exc_ctrl (honours EXC_BD_EN)
module tb_exc_ctrl;
  localparam int F = 2;
  localparam logic [31:0] HANDLER = 32'h0000_4180;
  logic        Clk = 0, Reset = 0;
  logic        ExcReqM = 0, BDM = 0, EretM = 0;
  logic [4:0]  ExcCodeM = 0;
  logic [31:0] PCM = 0, SRIn = 0, EPCIn = 0;
  logic [5:0]  HWInt = 0;
  logic        CP0Req, CP0BD, CP0EXLClr, FlushAll, NPCSel, Busy;
  logic [4:0]  CP0ExcCode;
  logic [31:0] CP0VPC, NPC;
  logic [5:0]  IPOut;
  logic [7:0]  DropCnt;

  exc_ctrl #(.HANDLER_ADDR(HANDLER), .FLUSH_CYCLES(F)) dut (
    .Clk(Clk), .Reset(Reset), .ExcReqM(ExcReqM), .ExcCodeM(ExcCodeM), .PCM(PCM), .BDM(BDM),
    .EretM(EretM), .HWInt(HWInt), .SRIn(SRIn), .EPCIn(EPCIn), .CP0Req(CP0Req),
    .CP0ExcCode(CP0ExcCode), .CP0VPC(CP0VPC), .CP0BD(CP0BD), .CP0EXLClr(CP0EXLClr),
    .IPOut(IPOut), .FlushAll(FlushAll), .NPCSel(NPCSel), .NPC(NPC), .Busy(Busy), .DropCnt(DropCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {logic [4:0] code; logic [31:0] vpc; logic bd;} cp0_t;
  typedef struct {logic ret; logic [31:0] npc;} redir_t;
  cp0_t   exp_cp0[$];
  redir_t exp_npc[$];
  int tests = 0, errs = 0;
  int busy_left = 0, fl_cnt = 0;
  logic busy_now = 0, ret_hold = 0, in_seq = 0;
  logic [5:0] prev_hw = 0, hw_cur = 0;
  logic [7:0] drop_now = 0, drop_next = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus plus the reference model of what the controller must do with it
  task automatic step(input logic er, input logic [4:0] ec, input logic [31:0] pc, input logic bd,
                      input logic et, input logic [5:0] hw, input logic [31:0] sr, input logic [31:0] epc);
    logic intp;
    cp0_t c;
    redir_t r;
    @(posedge Clk);
    #1;
    drop_now = drop_next;
    prev_hw  = hw_cur;
    busy_now = busy_left != 0;
    ExcReqM = er; ExcCodeM = ec; PCM = pc; BDM = bd; EretM = et; HWInt = hw; SRIn = sr;
    if (!ret_hold) EPCIn = epc;
    ret_hold = 0;
    hw_cur = hw;
    if (busy_left == 0) begin
      intp = |(prev_hw & sr[15:10]) && sr[0] && !sr[1];
      if (intp || (er && !sr[1])) begin
        c.code = intp ? 5'd0 : ec;
`ifdef EXC_BD_EN
        c.vpc = bd ? pc - 32'd4 : pc;
        c.bd  = bd;
`else
        c.vpc = pc;
        c.bd  = 1'b0;
`endif
        exp_cp0.push_back(c);
        r.ret = 0; r.npc = HANDLER;
        exp_npc.push_back(r);
        busy_left = 2 + F;
      end else if (et) begin
        r.ret = 1; r.npc = EPCIn;
        exp_npc.push_back(r);
        busy_left = 1;
        ret_hold = 1;
      end
      if (er && sr[1] && drop_next != 8'd255) drop_next++;
    end else busy_left--;
  endtask

  task automatic idle_steps(input int n, input logic [31:0] sr);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 0, 6'h0, sr, 32'h0);
  endtask

  // Monitor: per-cycle state checks plus scoreboard pops on CP0 strobes and redirects
  always @(negedge Clk) if (Reset) begin
    cp0_t c;
    redir_t r;
    chk("ipout", IPOut, prev_hw);
    chk("dropcnt", DropCnt, drop_now);
    chk("busy", Busy, busy_now);
    if (FlushAll && in_seq) fl_cnt++;
    if (CP0Req) begin
      if (exp_cp0.size() == 0) chk("unexpected_cp0req", 1, 0);
      else begin
        c = exp_cp0.pop_front();
        chk("cp0_code", CP0ExcCode, c.code);
        chk("cp0_vpc", CP0VPC, c.vpc);
        chk("cp0_bd", CP0BD, c.bd);
        chk("take_flush", FlushAll, 1);
      end
      in_seq = 1;
      fl_cnt = 1;
    end
    if (NPCSel) begin
      if (exp_npc.size() == 0) chk("unexpected_npcsel", 1, 0);
      else begin
        r = exp_npc.pop_front();
        chk("npc", NPC, r.npc);
        chk("exlclr", CP0EXLClr, r.ret);
        chk("redir_flush", FlushAll, r.ret);
        if (!r.ret) chk("flush_window", fl_cnt, 1 + F);
      end
      in_seq = 0;
    end else if (CP0EXLClr) chk("stray_exlclr", 1, 0);
  end

  initial begin
    ExcReqM = 1; ExcCodeM = 5'd9; PCM = 32'h1234; EretM = 1; HWInt = 6'h3F; SRIn = 32'hFFFF_FC01; EPCIn = 32'h55;
    #2;
    chk("reset_outs", {CP0Req, CP0ExcCode, CP0VPC, CP0BD, CP0EXLClr, IPOut, FlushAll, NPCSel, NPC, Busy, DropCnt}, 0);
    @(posedge Clk); #1;
    chk("reset_held", {CP0Req, CP0ExcCode, CP0VPC, CP0BD, CP0EXLClr, IPOut, FlushAll, NPCSel, NPC, Busy, DropCnt}, 0);
    ExcReqM = 0; ExcCodeM = 0; PCM = 0; EretM = 0; HWInt = 0; SRIn = 0; EPCIn = 0;
    #2 Reset = 1;
    idle_steps(2, 0);
    // interrupt entry with handler redirect
    step(0, 0, 32'h3000, 0, 0, 6'b000001, 32'h0000_0401, 0);
    step(0, 0, 32'h3000, 0, 0, 6'b000001, 32'h0000_0401, 0);
    idle_steps(6, 0);
    // synchronous exception in a delay slot
    step(1, 5'd12, 32'h3010, 1, 0, 0, 0, 0);
    idle_steps(6, 0);
    // interrupt beats a same-cycle exception
    step(0, 0, 32'h3100, 0, 0, 6'b000100, 32'h0000_1001, 0);
    step(1, 5'd4, 32'h3104, 0, 0, 6'b000100, 32'h0000_1001, 0);
    idle_steps(6, 0);
    // exception dropped while EXL set, then eret
    step(1, 5'd8, 32'h3018, 0, 0, 0, 32'h2, 0);
    step(0, 0, 32'h301C, 0, 1, 0, 32'h2, 32'h3020);
    idle_steps(3, 0);
    // all lines high but all masked
    for (int i = 0; i < 4; i++) step(0, 0, 32'h3200, 0, 0, 6'h3F, 32'h1, 0);
    idle_steps(2, 0);
    // drop counter saturation
    for (int i = 0; i < 300; i++) step(1, 5'd3, 32'h3300, 0, 0, 0, 32'h2, 0);
    idle_steps(2, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] sr;
      sr = {16'h0, 6'($urandom), 8'h0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0)};
      step($urandom_range(0, 9) < 3, 5'($urandom), $urandom & 32'hFFFF_FFFC, 1'($urandom),
           $urandom_range(0, 9) < 2, $urandom_range(0, 3) == 0 ? 6'($urandom) : 6'h0, sr, $urandom);
    end
    idle_steps(8, 0);
    // reset during the flush window aborts the sequence
    step(1, 5'd5, 32'h3400, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    #2 Reset = 0;
    #1;
    chk("async_reset_outs", {CP0Req, CP0ExcCode, CP0VPC, CP0BD, CP0EXLClr, IPOut, FlushAll, NPCSel, NPC, Busy, DropCnt}, 0);
    exp_cp0.delete(); exp_npc.delete();
    busy_left = 0; busy_now = 0; ret_hold = 0; in_seq = 0; fl_cnt = 0;
    prev_hw = 0; drop_now = 0; drop_next = 0;
    Reset = 1;
    idle_steps(8, 0);
    chk("cp0_queue_drained", exp_cp0.size(), 0);
    chk("npc_queue_drained", exp_npc.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
